// File: rtl/heatmap_pixel_writer_if.sv
// heatmap_pixel_writer_if: Avalon-MM write bundle between the pixel writer and the pixel buffer
interface heatmap_pixel_writer_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [PIX_W-1:0]  avm_writedata;
  logic              avm_waitrequest;
  modport master (output avm_address, avm_write, avm_writedata, input avm_waitrequest);
  modport slave (input avm_address, avm_write, avm_writedata, output avm_waitrequest);
endinterface

// File: rtl/heatmap_pixel_writer.sv
// heatmap_pixel_writer: turns HPS PIO pixel commits into queued Avalon-MM pixel-buffer writes
module heatmap_pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            x_coord,
  input  logic [31:0]            y_coord,
  input  logic [31:0]            pixel_color,
  input  logic                   commit_toggle,
  heatmap_pixel_writer_if.master avm,
  output logic                   busy,
  output logic                   done_toggle,
  output logic [15:0]            drop_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + PIX_W;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0] cnt_q;
  logic toggle_q, armed_q, done_q, done_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic [15:0] drop_q;
  logic commit, oor, full, push, drop, pop;
  assign commit = armed_q && (commit_toggle != toggle_q);
  assign oor = (x_coord >= 32'(H_RES)) || (y_coord >= 32'(V_RES));
  assign full = cnt_q == (PTR_W+1)'(FIFO_DEPTH);
  assign push = commit && !oor && !full;
  assign drop = commit && (oor || full);
  assign busy = (cnt_q != '0) || (state_q == WRITE);
  assign avm.avm_address = addr_q;
  assign avm.avm_write = write_q;
  assign avm.avm_writedata = data_q;
  assign done_toggle = done_q;
  assign drop_count = drop_q;
  // Request queue; the head stays queued until its write is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {ADDR_W'(y_coord * 32'(H_RES) + x_coord), PIX_W'(pixel_color)};
        wr_q <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
  // Commit edge detection, drop counter and bus-side registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      write_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= '0;
    end else begin
      toggle_q <= commit_toggle;
      armed_q <= 1'b1;
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      write_q <= write_d;
      done_q <= done_d;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
  // Write FSM: launch the head from IDLE, chain entries back-to-back on acceptance
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    write_d = write_q;
    done_d = done_q;
    pop = 1'b0;
    if (state_q == IDLE) begin
      if (cnt_q != '0) begin
        {addr_d, data_d} = mem_q[rd_q];
        write_d = 1'b1;
        state_d = WRITE;
      end
    end else if (!avm.avm_waitrequest) begin
      pop = 1'b1;
      done_d = !done_q;
      if (cnt_q > (PTR_W+1)'(1)) begin
        {addr_d, data_d} = mem_q[rd_q + PTR_W'(1)];
      end else begin
        write_d = 1'b0;
        state_d = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_heatmap_pixel_writer.sv
// tb_heatmap_pixel_writer: directed and randomized checks of the heat-map pixel writer
module tb_heatmap_pixel_writer;
  localparam int H = 640, V = 480, AW = 19, PW = 8, D = 4;
  logic clk = 1'b0, reset_n = 1'b0, tog = 1'b0;
  logic [31:0] x = '0, y = '0, c = '0;
  logic busy, done, exp_done = 1'b0;
  logic [15:0] drops;
  int tests = 0, fails = 0;
  heatmap_pixel_writer_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();
  heatmap_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(PW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .x_coord(x), .y_coord(y), .pixel_color(c),
    .commit_toggle(tog), .avm(bus), .busy(busy), .done_toggle(done), .drop_count(drops)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic commit(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] ci);
    x = xi;
    y = yi;
    c = ci;
    tog = ~tog;
  endtask

  function automatic logic [AW-1:0] lin(input logic [31:0] xi, input logic [31:0] yi);
    int unsigned a;
    a = yi * H + xi;
    return AW'(a % (1 << AW));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.avm_write, bus.avm_address, bus.avm_writedata, done, busy, drops} !== '0) begin
      fails++;
      $display("FAIL reset_hold: write=%b addr=%0d data=%h done=%b busy=%b drops=%0d, required all 0",
               bus.avm_write, bus.avm_address, bus.avm_writedata, done, busy, drops);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    tests++;
    if ({bus.avm_write, done, busy, drops} !== '0) begin
      fails++;
      $display("FAIL reset_release: write=%b done=%b busy=%b drops=%0d, required all 0",
               bus.avm_write, done, busy, drops);
    end
  endtask

  task automatic test_single();
    do_reset();
    commit(32'd3, 32'd2, 32'hA5);
    step();
    tests++;
    if (bus.avm_write !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_e0: write=%b busy=%b, required write=0 busy=1", bus.avm_write, busy);
    end
    step();
    tests++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 19'd1283 || bus.avm_writedata !== 8'hA5) begin
      fails++;
      $display("FAIL single_e1: write=%b addr=%0d data=%h, required 1/1283/a5",
               bus.avm_write, bus.avm_address, bus.avm_writedata);
    end
    step();
    exp_done = ~exp_done;
    tests++;
    if (bus.avm_write !== 1'b0 || done !== exp_done || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_e2: write=%b done=%b busy=%b, required 0/%b/0", bus.avm_write, done, busy, exp_done);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    commit(32'd640, 32'd0, 32'h11);
    step();
    commit(32'd0, 32'd480, 32'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (bus.avm_write !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL oor_idle: write=%b busy=%b, required 0/0", bus.avm_write, busy);
      end
    end
    tests++;
    if (drops !== 16'd2) begin
      fails++;
      $display("FAIL oor_drops: drops=%0d, required 2", drops);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.avm_waitrequest = 1'b1;
    repeat (5) step();
    for (int i = 0; i < 6; i++) begin
      commit(32'(i * 10 + 1), 32'(i + 5), 32'(16 + i));
      step();
    end
    tests++;
    if (drops !== 16'd2) begin
      fails++;
      $display("FAIL stall_drops: drops=%0d, required 2", drops);
    end
    repeat (3) begin
      tests++;
      if (bus.avm_write !== 1'b1 || bus.avm_address !== lin(1, 5) || bus.avm_writedata !== 8'h10) begin
        fails++;
        $display("FAIL stall_hold: write=%b addr=%0d data=%h, required 1/%0d/10",
                 bus.avm_write, bus.avm_address, bus.avm_writedata, lin(1, 5));
      end
      step();
    end
    bus.avm_waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bus.avm_write !== 1'b1 || bus.avm_address !== lin(32'(k * 10 + 1), 32'(k + 5)) ||
          bus.avm_writedata !== 8'(16 + k) || done !== exp_done) begin
        fails++;
        $display("FAIL stall_drain%0d: write=%b addr=%0d data=%h done=%b, required 1/%0d/%h/%b", k,
                 bus.avm_write, bus.avm_address, bus.avm_writedata, done,
                 lin(32'(k * 10 + 1), 32'(k + 5)), 8'(16 + k), exp_done);
      end
      step();
      exp_done = ~exp_done;
    end
    tests++;
    if (bus.avm_write !== 1'b0 || done !== exp_done || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_end: write=%b done=%b busy=%b, required 0/%b/0", bus.avm_write, done, busy, exp_done);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    bus.avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      commit(32'(i), 32'd7, 32'(64 + i));
      step();
    end
    tests++;
    if (drops !== 16'd0 || bus.avm_write !== 1'b1 || bus.avm_address !== lin(0, 7)) begin
      fails++;
      $display("FAIL full_setup: drops=%0d write=%b addr=%0d, required 0/1/%0d",
               drops, bus.avm_write, bus.avm_address, lin(0, 7));
    end
    bus.avm_waitrequest = 1'b0;
    commit(32'd100, 32'd7, 32'hEE);
    step();
    tests++;
    if (drops !== 16'd1) begin
      fails++;
      $display("FAIL full_pop_drop: drops=%0d, required 1", drops);
    end
    for (int k = 1; k < 4; k++) begin
      tests++;
      if (bus.avm_write !== 1'b1 || bus.avm_address !== lin(32'(k), 7) || bus.avm_writedata !== 8'(64 + k)) begin
        fails++;
        $display("FAIL full_drain%0d: write=%b addr=%0d data=%h, required 1/%0d/%h", k,
                 bus.avm_write, bus.avm_address, bus.avm_writedata, lin(32'(k), 7), 8'(64 + k));
      end
      step();
    end
    tests++;
    if (bus.avm_write !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_end: write=%b busy=%b, required 0/0", bus.avm_write, busy);
    end
  endtask

  task automatic test_random();
    logic [AW+PW-1:0] q[$];
    logic [15:0] mdrop;
    logic pw, pwr, wr, cm, acc, dropit;
    logic [AW-1:0] pa;
    logic [PW-1:0] pd;
    logic [31:0] xi, yi, ci;
    int sel;
    mdrop = '0;
    pw = 1'b0;
    pwr = 1'b0;
    pa = '0;
    pd = '0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      tests++;
      if (drops !== mdrop || done !== exp_done) begin
        fails++;
        $display("FAIL rand_state@%0d: drops=%0d done=%b, required %0d/%b", n, drops, done, mdrop, exp_done);
      end
      if (pw && pwr) begin
        tests++;
        if (bus.avm_write !== 1'b1 || bus.avm_address !== pa || bus.avm_writedata !== pd) begin
          fails++;
          $display("FAIL rand_hold@%0d: write=%b addr=%0d data=%h, required 1/%0d/%h",
                   n, bus.avm_write, bus.avm_address, bus.avm_writedata, pa, pd);
        end
      end
      wr = n < 570 && $urandom_range(0, 2) == 0;
      cm = n < 560 && $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 9);
      xi = $urandom_range(0, H + 20);
      yi = $urandom_range(0, V + 10);
      ci = $urandom;
      if (sel == 0) xi = $urandom;
      if (sel == 1) yi = $urandom | 32'h8000_0000;
      if (sel == 2) begin xi = H - 1; yi = V - 1; end
      if (sel == 3) begin xi = H; yi = 0; end
      bus.avm_waitrequest = wr;
      acc = bus.avm_write && !wr;
      dropit = cm && (xi >= H || yi >= V || q.size() == D);
      if (dropit && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      if (acc) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_spurious@%0d: write with addr=%0d accepted, required no write", n, bus.avm_address);
        end else begin
          if ({bus.avm_address, bus.avm_writedata} !== q[0]) begin
            fails++;
            $display("FAIL rand_write@%0d: addr=%0d data=%h, required %0d/%h", n,
                     bus.avm_address, bus.avm_writedata, q[0][AW+PW-1:PW], q[0][PW-1:0]);
          end
          void'(q.pop_front());
        end
        exp_done = ~exp_done;
      end
      if (cm && !dropit) q.push_back({lin(xi, yi), ci[PW-1:0]});
      if (cm) commit(xi, yi, ci);
      pw = bus.avm_write;
      pwr = wr;
      pa = bus.avm_address;
      pd = bus.avm_writedata;
      step();
    end
    tests++;
    if (q.size() != 0 || busy !== 1'b0 || bus.avm_write !== 1'b0 || done !== exp_done || drops !== mdrop) begin
      fails++;
      $display("FAIL rand_end: pending=%0d busy=%b write=%b done=%b drops=%0d, required 0/0/0/%b/%0d",
               q.size(), busy, bus.avm_write, done, drops, exp_done, mdrop);
    end
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    bus.avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      commit(32'(i + 20), 32'd1, 32'(i + 1));
      step();
    end
    step();
    tests++;
    if (bus.avm_write !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_setup: write=%b busy=%b, required 1/1", bus.avm_write, busy);
    end
    #2;
    reset_n = 1'b0;
    tog = 1'b1;
    #1;
    tests++;
    if ({bus.avm_write, bus.avm_address, bus.avm_writedata, done, busy, drops} !== '0) begin
      fails++;
      $display("FAIL midrst_async: write=%b addr=%0d data=%h done=%b busy=%b drops=%0d, required all 0",
               bus.avm_write, bus.avm_address, bus.avm_writedata, done, busy, drops);
    end
    @(negedge clk);
    bus.avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    exp_done = 1'b0;
    repeat (4) begin
      step();
      tests++;
      if ({bus.avm_write, done, busy, drops} !== '0) begin
        fails++;
        $display("FAIL midrst_release: write=%b done=%b busy=%b drops=%0d, required all 0",
                 bus.avm_write, done, busy, drops);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      if (i == 65534) begin
        tests++;
        if (drops !== 16'hFFFE) begin
          fails++;
          $display("FAIL sat_below: drops=%h, required fffe", drops);
        end
      end
      if (i == 65535) begin
        tests++;
        if (drops !== 16'hFFFF) begin
          fails++;
          $display("FAIL sat_reach: drops=%h, required ffff", drops);
        end
      end
      commit(32'd700, 32'd0, 32'h0);
      step();
    end
    tests++;
    if (drops !== 16'hFFFF || busy !== 1'b0 || bus.avm_write !== 1'b0) begin
      fails++;
      $display("FAIL sat_hold: drops=%h busy=%b write=%b, required ffff/0/0", drops, busy, bus.avm_write);
    end
  endtask

  initial begin
    bus.avm_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_out_of_range();
    test_stall();
    test_full_pop();
    test_random();
    test_reset_midwrite();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
